mem_rmw_responder: RTL and testbench

- Memory-side responder for the CPU's load/store port. It accepts one request at a time: word, half or byte, read or write.
- It drives a word-wide synchronous RAM with 1-cycle read latency.
- Partial stores are handled by read-modify-write. Loads return sign- or zero-extended data.
- Sits between the multicycle datapath's memory port and the RAM. It answers each request with a single-cycle `ack`.

---
 rtl/mem_resp_pkg.sv | 36 +++
 rtl/lane_merge.sv | 39 +++
 rtl/mem_rmw_responder.sv | 159 +++++++++++++++
 tb/tb_mem_rmw_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the memory read-modify-write responder.
package mem_resp_pkg;

    localparam int unsigned DW = 32;

    // Access size encoding; 2'b11 is the illegal encoding.
    typedef enum logic [1:0] {
        SZ_WORD = 2'b00,
        SZ_HALF = 2'b01,
        SZ_BYTE = 2'b10
    } size_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WRITE   = 3'd3,
        ST_ACK     = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    // True for the illegal size or an address not aligned to the access size.
    function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        if (size == 2'b11) begin
            bad = 1'b1;
        end else if ((size == SZ_HALF) && off[0]) begin
            bad = 1'b1;
        end else if ((size == SZ_WORD) && (off != 2'b00)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lane_merge.sv
// Little-endian lane logic: builds the merged store word and the extended load value.
module lane_merge
    import mem_resp_pkg::*;
(
    input  logic [DW-1:0] word_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [1:0]    offset_i,
    input  logic [1:0]    size_i,
    input  logic          uns_i,
    output logic [DW-1:0] store_c,
    output logic [DW-1:0] load_c
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Lane select, replace and extend for the addressed byte or half.
    always_comb begin
        byte_sh = {offset_i, 3'b000};
        half_sh = {offset_i[1], 4'b0000};
        byte_v  = 8'(word_i >> byte_sh);
        half_v  = 16'(word_i >> half_sh);
        store_c = word_i;
        load_c  = word_i;
        if (size_i == SZ_WORD) begin
            store_c = wdata_i;
            load_c  = word_i;
        end else if (size_i == SZ_HALF) begin
            store_c = (word_i & ~(32'h0000_FFFF << half_sh)) | (32'(wdata_i[15:0]) << half_sh);
            load_c  = uns_i ? 32'(half_v) : {{16{half_v[15]}}, half_v};
        end else if (size_i == SZ_BYTE) begin
            store_c = (word_i & ~(32'h0000_00FF << byte_sh)) | (32'(wdata_i[7:0]) << byte_sh);
            load_c  = uns_i ? 32'(byte_v) : {{24{byte_v[7]}}, byte_v};
        end
    end

endmodule

// File: rtl/mem_rmw_responder.sv
// Load/store responder in front of a word-wide synchronous RAM; partial stores use read-modify-write.
module mem_rmw_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned AW = 8
)
(
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req,
    input  logic          wr,
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [31:0]   addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          ack,
    output logic          misalign,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [31:0]   ram_wdata,
    input  logic [31:0]   ram_rdata
);

    state_t          state_q, state_d;
    logic            wr_q, wr_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      off_q, off_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdbuf_q, rdbuf_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            mis_q, mis_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic            ram_we_q, ram_we_d;
    logic [DW-1:0]   ram_wdata_q, ram_wdata_d;

    logic            accept_c;
    logic            err_c;
    logic [DW-1:0]   store_c;
    logic [DW-1:0]   load_c;
    logic            unused_addr_hi;

    // Upper address bits wrap modulo the RAM size.
    assign unused_addr_hi = ^addr[31:AW+2];

    // Merge/extend operates on next-cycle values so WRITE/ACK outputs register in time.
    lane_merge u_lane_merge (
        .word_i   (rdbuf_d),
        .wdata_i  (wdata_d),
        .offset_i (off_d),
        .size_i   (size_d),
        .uns_i    (uns_d),
        .store_c  (store_c),
        .load_c   (load_c)
    );

    // Next-state, request latching and registered-output next values.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        size_d      = size_q;
        uns_d       = uns_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rdbuf_d     = rdbuf_q;
        ram_addr_d  = ram_addr_q;
        accept_c    = 1'b0;
        err_c       = 1'b0;

        if (state_q == ST_IDLE && req) begin
            accept_c = 1'b1;
            err_c    = is_misaligned(addr[1:0], size);
        end

        if (accept_c) begin
            wr_d    = wr;
            size_d  = size;
            uns_d   = uns;
            off_d   = addr[1:0];
            wdata_d = wdata;
            if (!err_c) begin
                ram_addr_d = addr[AW+1:2];
            end
        end

        if (state_q == ST_RD_WAIT) begin
            rdbuf_d = ram_rdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (err_c) begin
                        state_d = ST_ERR;
                    end else if (wr && (size == SZ_WORD)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:      state_d = ST_RD_WAIT;
            ST_RD_WAIT: state_d = wr_q ? ST_WRITE : ST_ACK;
            ST_WRITE:   state_d = ST_ACK;
            ST_ACK:     state_d = ST_IDLE;
            ST_ERR:     state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        ack_d       = (state_d == ST_ACK) || (state_d == ST_ERR);
        mis_d       = (state_d == ST_ERR);
        ram_we_d    = (state_d == ST_WRITE);
        ram_wdata_d = ram_we_d ? store_c : ram_wdata_q;
        rdata_d     = ((state_d == ST_ACK) && !wr_d) ? load_c : rdata_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            wdata_q     <= '0;
            rdbuf_q     <= '0;
            rdata_q     <= '0;
            ack_q       <= 1'b0;
            mis_q       <= 1'b0;
            ram_addr_q  <= '0;
            ram_we_q    <= 1'b0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            rdbuf_q     <= rdbuf_d;
            rdata_q     <= rdata_d;
            ack_q       <= ack_d;
            mis_q       <= mis_d;
            ram_addr_q  <= ram_addr_d;
            ram_we_q    <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign rdata     = rdata_q;
    assign ack       = ack_q;
    assign misalign  = mis_q;
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_mem_rmw_responder.sv
// Directed scoreboard bench for mem_rmw_responder with a behavioural 1-cycle-latency RAM.
module tb_mem_rmw_responder;

    localparam int unsigned AW = 8;

    logic          Clk;
    logic          Reset;
    logic          req;
    logic          wr;
    logic [1:0]    size;
    logic          uns;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          ack;
    logic          misalign;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    typedef struct {
        int            lat;
        logic [31:0]   rdata;
        logic          mis;
        int            wes;
        logic [AW-1:0] waddr;
        logic [31:0]   wdata;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    int            we_cnt = 0;
    int            we_base = 0;
    logic [AW-1:0] last_we_addr;
    logic [31:0]   last_we_data;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [31:0]   pre_data;

    mem_rmw_responder #(.AW(AW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req       (req),
        .wr        (wr),
        .size      (size),
        .uns       (uns),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .ack       (ack),
        .misalign  (misalign),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Synchronous RAM with a bench-side preload port.
    always @(posedge Clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    // Write-pulse monitor.
    always @(posedge Clk) begin
        if (ram_we === 1'b1) begin
            we_cnt       = we_cnt + 1;
            last_we_addr = ram_addr;
            last_we_data = ram_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int lat, input logic [31:0] rd, input logic mis,
                                input int wes, input logic [AW-1:0] wa, input logic [31:0] wd);
        exp_t e;
        e.lat = lat; e.rdata = rd; e.mis = mis; e.wes = wes; e.waddr = wa; e.wdata = wd;
        return e;
    endfunction

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge Clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge Clk);
        pre_we = 1'b0;
    endtask

    task automatic drive(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, input exp_t e, input bit hold);
        @(negedge Clk);
        req = 1'b1; wr = w; size = sz; uns = u; addr = a; wdata = wd;
        sb.push_back(e);
        we_base = we_cnt;
        @(posedge Clk);
        #1;
        if (!hold) begin
            req = 1'b0; wr = ~w; size = 2'b11; uns = ~u; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        end
    endtask

    task automatic wait_ack(input string tag);
        exp_t e;
        int   lat;
        bit   got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 12) begin
            @(negedge Clk);
            lat++;
            got = (ack === 1'b1);
        end
        e = sb.pop_front();
        check({tag, ".ack_seen"}, 32'(got), 32'd1);
        check({tag, ".latency"}, 32'(lat), 32'(e.lat));
        check({tag, ".misalign"}, 32'(misalign), 32'(e.mis));
        check({tag, ".rdata"}, rdata, e.rdata);
        check({tag, ".we_pulses"}, 32'(we_cnt - we_base), 32'(e.wes));
        if (e.wes > 0) begin
            check({tag, ".we_addr"}, 32'(last_we_addr), 32'(e.waddr));
            check({tag, ".we_data"}, last_we_data, e.wdata);
        end
        we_base = we_cnt;
    endtask

    task automatic pulse_end(input string tag);
        @(negedge Clk);
        check({tag, ".ack_low"}, 32'(ack), 32'd0);
        check({tag, ".mis_low"}, 32'(misalign), 32'd0);
    endtask

    task automatic txn(input string tag, input logic w, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd, input exp_t e);
        drive(w, sz, u, a, wd, e, 1'b0);
        wait_ack(tag);
        pulse_end(tag);
    endtask

    initial begin
        bit saw_ack;
        int base;

        Reset = 1'b1; req = 1'b0; wr = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        repeat (3) @(negedge Clk);
        check("rst.rdata", rdata, 32'h0);
        check("rst.ack", 32'(ack), 32'd0);
        check("rst.misalign", 32'(misalign), 32'd0);
        check("rst.ram_we", 32'(ram_we), 32'd0);
        check("rst.ram_addr", 32'(ram_addr), 32'd0);
        check("rst.ram_wdata", ram_wdata, 32'h0);
        Reset = 1'b0;

        preload(8'h40, 32'h1122_3344);
        preload(8'h41, 32'hCAFE_F00D);

        txn("lw100", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, mk(3, 32'h1122_3344, 1'b0, 0, 8'h0, 32'h0));
        txn("sb101", 1'b1, 2'b10, 1'b0, 32'h101, 32'hFFFF_FFAB,
            mk(4, 32'h1122_3344, 1'b0, 1, 8'h40, 32'h1122_AB44));
        txn("lw100b", 1'b0, 2'b00, 1'b1, 32'h100, 32'h0, mk(3, 32'h1122_AB44, 1'b0, 0, 8'h0, 32'h0));

        preload(8'h40, 32'h0000_80F0);
        txn("lb101", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, mk(3, 32'hFFFF_FF80, 1'b0, 0, 8'h0, 32'h0));
        txn("lbu101", 1'b0, 2'b10, 1'b1, 32'h101, 32'h0, mk(3, 32'h0000_0080, 1'b0, 0, 8'h0, 32'h0));
        txn("lh100", 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, mk(3, 32'hFFFF_80F0, 1'b0, 0, 8'h0, 32'h0));
        txn("lb100", 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, mk(3, 32'hFFFF_FFF0, 1'b0, 0, 8'h0, 32'h0));
        txn("lhu102", 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, mk(3, 32'h0000_0000, 1'b0, 0, 8'h0, 32'h0));
        txn("sh102", 1'b1, 2'b01, 1'b0, 32'h102, 32'h1234_BEEF,
            mk(4, 32'h0000_0000, 1'b0, 1, 8'h40, 32'hBEEF_80F0));
        txn("lw100c", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, mk(3, 32'hBEEF_80F0, 1'b0, 0, 8'h0, 32'h0));

        txn("lh103", 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, mk(1, 32'hBEEF_80F0, 1'b1, 0, 8'h0, 32'h0));
        txn("sz11", 1'b0, 2'b11, 1'b0, 32'h100, 32'h0, mk(1, 32'hBEEF_80F0, 1'b1, 0, 8'h0, 32'h0));
        txn("sw102", 1'b1, 2'b00, 1'b0, 32'h102, 32'h0, mk(1, 32'hBEEF_80F0, 1'b1, 0, 8'h0, 32'h0));

        txn("lwwrap", 1'b0, 2'b00, 1'b0, 32'h0000_0504, 32'h0,
            mk(3, 32'hCAFE_F00D, 1'b0, 0, 8'h0, 32'h0));

        // Byte store interrupted by reset while in RD_WAIT.
        @(negedge Clk);
        req = 1'b1; wr = 1'b1; size = 2'b10; uns = 1'b0; addr = 32'h100; wdata = 32'h0000_0055;
        base = we_cnt;
        @(posedge Clk);
        #1;
        req = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        saw_ack = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            if (ack === 1'b1) saw_ack = 1'b1;
        end
        check("rstmid.no_ack", 32'(saw_ack), 32'd0);
        check("rstmid.no_we", 32'(we_cnt - base), 32'd0);
        check("rstmid.rdata", rdata, 32'h0);
        txn("rstmid.readback", 1'b0, 2'b00, 1'b0, 32'h100, 32'h0,
            mk(3, 32'hBEEF_80F0, 1'b0, 0, 8'h0, 32'h0));

        // Back-to-back with req held high: store word, then load it back.
        drive(1'b1, 2'b00, 1'b0, 32'h200, 32'hDEAD_BEEF,
              mk(2, 32'hBEEF_80F0, 1'b0, 1, 8'h80, 32'hDEAD_BEEF), 1'b1);
        wr = 1'b0; size = 2'b00; uns = 1'b0; addr = 32'h200; wdata = 32'h0;
        wait_ack("b2b.sw");
        sb.push_back(mk(4, 32'hDEAD_BEEF, 1'b0, 0, 8'h0, 32'h0));
        wait_ack("b2b.lw");
        req = 1'b0;
        pulse_end("b2b");

        repeat (2) @(negedge Clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
